alu_flag_unit: RTL and testbench
================================

Name: alu_flag_unit

Overview:
- Accumulator-style datapath slice: a combinational ALU producing a DATA_WIDTH+1 bit result (carry/borrow in the MSB), plus a clocked flag register capturing Zero/Sign/Carry from that result.
- Sits between the accumulator/operand muxes and the control unit.
- The control unit uses the registered flags for conditional branches and for carry-chained ADD/SUB.

Parameters:
- DATA_WIDTH, 8, operand and result data width in bits.
- ALU_OP_BITS, 4, width of the operation select.

Ports:
- clk  input  1  rising-edge clock for the flag register.
- reset  input  1  asynchronous, active-low reset of the flag register.
- acc  input  DATA_WIDTH  accumulator operand (A).
- src  input  DATA_WIDTH  source operand (B).
- alu_op  input  ALU_OP_BITS  operation select.
- carry_in  input  1  carry/borrow input for ADD/SUB.
- update_flags  input  1  when high, flags load on the next rising clk edge.
- temp_result  output  DATA_WIDTH+1  combinational result; bit DATA_WIDTH is carry/borrow out.
- zero_flag  output  1  registered Z.
- sign_flag  output  1  registered S.
- carry_flag  output  1  registered C.

Behaviour:
- Result path:
  - temp_result is purely combinational from acc, src, alu_op and carry_in, with zero cycle latency.
  - N denotes DATA_WIDTH.
  - Arithmetic is unsigned at N+1 bits, and all operands are zero-extended.
- Opcodes:
  - 0000 PASS: {0, src}.
  - 0001 ADD: acc + src + carry_in; bit N is the carry out.
  - 0010 SUB: acc - src - carry_in, taken modulo 2^(N+1); bit N is 1 on borrow.
  - 0011 INC: acc + 1; bit N is the carry out (FF gives 1_00).
  - 0100 DEC: acc - 1; bit N is the borrow (00 gives 1_FF).
  - 0101 RL: {acc[N-1], acc[N-2:0], acc[N-1]}, i.e. rotate left with the old MSB copied into bit N.
  - 0110 RR: {acc[0], acc[0], acc[N-1:1]}, i.e. rotate right with the old LSB copied into bit N.
  - 0111 AND, 1000 OR, 1001 XOR: bitwise acc op src, bit N = 0.
  - 1010 NOT: {0, ~acc}.
  - 1011-1111 (unused): result all zeros.
- carry_in is ignored by every op except ADD and SUB.
- Flag derivation from temp_result:
  - Z = (temp_result[N-1:0] == 0); the carry bit is excluded.
  - S = temp_result[N-1].
  - C = temp_result[N].
- Flag register:
  - reset low: Z, S and C clear to 0 immediately (asynchronous), and stay 0 while reset is low.
  - On a rising clk edge with reset high and update_flags=1: Z, S and C load from temp_result.
  - With update_flags=0: the flags hold.
  - Flags are visible one cycle after the result settles.
  - reset deasserting in the same cycle as an edge: that edge is ignored, and the flags remain 0 until the next edge.
- Flags are registered only. The flag register never feeds carry_in internally; feedback is the integrator's choice.

Optional Feature:
- Macro ALU_OVERFLOW_FLAG_EN adds an output port overflow_flag (1 bit, registered).
  - It has the same reset and update rules as the other flags.
  - ADD/INC: V = operands have the same sign and the result sign differs.
  - SUB/DEC: V = operands have different signs and the result sign differs from acc's.
  - All other ops: V = 0.
- Without the macro, the port and its logic are absent, and the remaining behaviour is identical.

Test Plan:
- Reset low for 2 cycles, with a nonzero result present -> Z=S=C=0. Then update_flags=1, PASS, src=55 -> temp_result=055; after one edge Z=0, S=0, C=0.
- ADD acc=01, src=02, cin=0 -> 003 (Z0 S0 C0). ADD acc=FF, src=01, cin=1 -> 101 (Z0 S0 C1).
- SUB acc=05, src=02, cin=1 -> 002 (C0). SUB acc=00, src=01, cin=0 -> 1FF (S1 C1).
- INC acc=0F -> 010. DEC acc=10 -> 00F. INC acc=FF -> 100 (Z1 C1).
- Rotates on acc=AA: RL -> 155 (C1 S0). RR -> 055 (C0).
- Logic on acc=F0, src=0F:
  - AND -> 000 (Z1).
  - OR -> 0FF (S1).
  - XOR -> 0FF.
- NOT acc=55 -> 0AA (S1).
- Flag hold: update_flags=0 while ops change -> flags unchanged.
- Reset asserted mid-run -> flags clear without a clock edge.

Source files
------------

// File: rtl/alu_flag_unit.sv
// alu_flag_unit: combinational ALU slice with a registered Zero/Sign/Carry flag register.
// The result is DATA_WIDTH+1 bits wide; the top bit carries the carry/borrow out.
// Optional build macro: ALU_OVERFLOW_FLAG_EN adds a registered signed-overflow flag output.
module alu_flag_unit #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ALU_OP_BITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  acc,
    input  logic [DATA_WIDTH-1:0]  src,
    input  logic [ALU_OP_BITS-1:0] alu_op,
    input  logic                   carry_in,
    input  logic                   update_flags,
    output logic [DATA_WIDTH:0]    temp_result,
    output logic                   zero_flag,
    output logic                   sign_flag,
    output logic                   carry_flag
`ifdef ALU_OVERFLOW_FLAG_EN
    ,
    output logic                   overflow_flag
`endif
);

    localparam int unsigned N = DATA_WIDTH;

    localparam logic [ALU_OP_BITS-1:0] OpPass = ALU_OP_BITS'(0);
    localparam logic [ALU_OP_BITS-1:0] OpAdd  = ALU_OP_BITS'(1);
    localparam logic [ALU_OP_BITS-1:0] OpSub  = ALU_OP_BITS'(2);
    localparam logic [ALU_OP_BITS-1:0] OpInc  = ALU_OP_BITS'(3);
    localparam logic [ALU_OP_BITS-1:0] OpDec  = ALU_OP_BITS'(4);
    localparam logic [ALU_OP_BITS-1:0] OpRl   = ALU_OP_BITS'(5);
    localparam logic [ALU_OP_BITS-1:0] OpRr   = ALU_OP_BITS'(6);
    localparam logic [ALU_OP_BITS-1:0] OpAnd  = ALU_OP_BITS'(7);
    localparam logic [ALU_OP_BITS-1:0] OpOr   = ALU_OP_BITS'(8);
    localparam logic [ALU_OP_BITS-1:0] OpXor  = ALU_OP_BITS'(9);
    localparam logic [ALU_OP_BITS-1:0] OpNot  = ALU_OP_BITS'(10);

    localparam logic [N:0] One = (N+1)'(1);

    logic [N:0] a_ext;
    logic [N:0] b_ext;
    logic [N:0] cin_ext;

    assign a_ext   = {1'b0, acc};
    assign b_ext   = {1'b0, src};
    assign cin_ext = {{N{1'b0}}, carry_in};

    // Result mux: unsigned N+1 bit arithmetic, unused opcodes produce zero.
    always_comb begin
        temp_result = '0;
        case (alu_op)
            OpPass:  temp_result = b_ext;
            OpAdd:   temp_result = a_ext + b_ext + cin_ext;
            OpSub:   temp_result = a_ext - b_ext - cin_ext;
            OpInc:   temp_result = a_ext + One;
            OpDec:   temp_result = a_ext - One;
            OpRl:    temp_result = {acc[N-1], acc[N-2:0], acc[N-1]};
            OpRr:    temp_result = {acc[0], acc[0], acc[N-1:1]};
            OpAnd:   temp_result = {1'b0, acc & src};
            OpOr:    temp_result = {1'b0, acc | src};
            OpXor:   temp_result = {1'b0, acc ^ src};
            OpNot:   temp_result = {1'b0, ~acc};
            default: temp_result = '0;
        endcase
    end

`ifdef ALU_OVERFLOW_FLAG_EN
    logic ovf_next;

    // Signed overflow: INC/DEC behave as ADD/SUB with a positive operand of one.
    always_comb begin
        ovf_next = 1'b0;
        case (alu_op)
            OpAdd:   ovf_next = (acc[N-1] == src[N-1]) && (temp_result[N-1] != acc[N-1]);
            OpSub:   ovf_next = (acc[N-1] != src[N-1]) && (temp_result[N-1] != acc[N-1]);
            OpInc:   ovf_next = !acc[N-1] && temp_result[N-1];
            OpDec:   ovf_next = acc[N-1] && !temp_result[N-1];
            default: ovf_next = 1'b0;
        endcase
    end

    // Overflow flag register, same reset/update rules as Z/S/C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_flag <= 1'b0;
        end else if (update_flags) begin
            overflow_flag <= ovf_next;
        end
    end
`endif

    // Z/S/C register; carry bit is excluded from the zero test.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_flag  <= 1'b0;
            sign_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else if (update_flags) begin
            zero_flag  <= (temp_result[N-1:0] == '0);
            sign_flag  <= temp_result[N-1];
            carry_flag <= temp_result[N];
        end
    end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed self-checking bench for alu_flag_unit (default 8-bit build).
module tb_alu_flag_unit;

    logic       clk;
    logic       reset;
    logic [7:0] acc;
    logic [7:0] src;
    logic [3:0] alu_op;
    logic       carry_in;
    logic       update_flags;
    logic [8:0] temp_result;
    logic       zero_flag;
    logic       sign_flag;
    logic       carry_flag;
`ifdef ALU_OVERFLOW_FLAG_EN
    logic       overflow_flag;
`endif

    int vectors;
    int miscompares;

    alu_flag_unit #(
        .DATA_WIDTH  (8),
        .ALU_OP_BITS (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .acc          (acc),
        .src          (src),
        .alu_op       (alu_op),
        .carry_in     (carry_in),
        .update_flags (update_flags),
        .temp_result  (temp_result),
        .zero_flag    (zero_flag),
        .sign_flag    (sign_flag),
        .carry_flag   (carry_flag)
`ifdef ALU_OVERFLOW_FLAG_EN
        ,
        .overflow_flag(overflow_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] flags();
        return {6'b0, zero_flag, sign_flag, carry_flag};
    endfunction

    // Drive after a falling edge, check the result combinationally, then the flags after the
    // next rising edge. exp_zsc is {Z,S,C}.
    task automatic step(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic cin, input logic [8:0] exp_res,
                        input logic [2:0] exp_zsc);
        @(negedge clk);
        alu_op   = op;
        acc      = a;
        src      = b;
        carry_in = cin;
        #1;
        check({tag, " result"}, temp_result, exp_res);
        @(posedge clk);
        #1;
        check({tag, " flags"}, flags(), {6'b0, exp_zsc});
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b0;
        update_flags = 1'b1;
        alu_op       = 4'b0001;
        acc          = 8'hFF;
        src          = 8'h01;
        carry_in     = 1'b1;

        // Reset held across two edges with a nonzero result present.
        repeat (2) @(posedge clk);
        #1;
        check("reset result", temp_result, 9'h101);
        check("reset flags", flags(), 9'h000);
        @(negedge clk);
        reset = 1'b1;

        step("pass55",   4'b0000, 8'h00, 8'h55, 1'b0, 9'h055, 3'b000);
        step("add1+2",   4'b0001, 8'h01, 8'h02, 1'b0, 9'h003, 3'b000);
        step("addff+1c", 4'b0001, 8'hFF, 8'h01, 1'b1, 9'h101, 3'b001);
        step("sub5-2b",  4'b0010, 8'h05, 8'h02, 1'b1, 9'h002, 3'b000);
        step("sub0-1",   4'b0010, 8'h00, 8'h01, 1'b0, 9'h1FF, 3'b011);
        step("inc0f",    4'b0011, 8'h0F, 8'h00, 1'b0, 9'h010, 3'b000);
        step("dec10",    4'b0100, 8'h10, 8'h00, 1'b0, 9'h00F, 3'b000);
        step("incff",    4'b0011, 8'hFF, 8'h00, 1'b0, 9'h100, 3'b101);
        step("dec00",    4'b0100, 8'h00, 8'h00, 1'b1, 9'h1FF, 3'b011);
        step("inc0fcin", 4'b0011, 8'h0F, 8'h00, 1'b1, 9'h010, 3'b000);
        step("rlaa",     4'b0101, 8'hAA, 8'h00, 1'b0, 9'h155, 3'b001);
        step("rraa",     4'b0110, 8'hAA, 8'h00, 1'b0, 9'h055, 3'b000);
        step("rr01",     4'b0110, 8'h01, 8'h00, 1'b0, 9'h180, 3'b011);
        step("and",      4'b0111, 8'hF0, 8'h0F, 1'b0, 9'h000, 3'b100);
        step("or",       4'b1000, 8'hF0, 8'h0F, 1'b0, 9'h0FF, 3'b010);
        step("xor",      4'b1001, 8'hF0, 8'h0F, 1'b0, 9'h0FF, 3'b010);
        step("xor3c",    4'b1001, 8'h3C, 8'h3C, 1'b1, 9'h000, 3'b100);
        step("not55",    4'b1010, 8'h55, 8'h00, 1'b0, 9'h0AA, 3'b010);
        step("add7f+1",  4'b0001, 8'h7F, 8'h01, 1'b0, 9'h080, 3'b010);
`ifdef ALU_OVERFLOW_FLAG_EN
        check("ovf add7f+1", {8'b0, overflow_flag}, 9'h001);
`endif
        step("unused",   4'b1011, 8'hFF, 8'hFF, 1'b1, 9'h000, 3'b100);

        // Flags hold while update_flags is low.
        update_flags = 1'b0;
        step("hold add", 4'b0001, 8'hFF, 8'h01, 1'b1, 9'h101, 3'b100);
        step("hold or",  4'b1000, 8'h80, 8'h00, 1'b0, 9'h080, 3'b100);
        update_flags = 1'b1;
        step("load or",  4'b1000, 8'h80, 8'h01, 1'b0, 9'h081, 3'b010);

        // Asynchronous clear away from any edge, then no loading while held.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async clear", flags(), 9'h000);
        step("in reset", 4'b0000, 8'h00, 8'h80, 1'b0, 9'h080, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        step("post reset", 4'b0000, 8'h00, 8'h80, 1'b0, 9'h080, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
